cnn_out_collector: RTL and testbench
====================================

// Module: cnn_out_collector
// PURPOSE
//  Receive-side counterpart of the accelerator timing generator. Consumes the vsync/hsync/data-run stream.
//  Takes one 8-bit result per accepted pixel and rebuilds row/col and pixel counts.
//  Packs 4 pixels per 32-bit word, little-endian, and writes them to the output SRAM.
//  Flags malformed frames and signals frame completion to the AHB register block.
// PARAMETERS
//  W_SIZE        12   width of width/height/row/col
//  W_FRAME_SIZE  25   width of frame-size and pixel counters (2*W_SIZE+1)
//  W_ADDR        16   SRAM word-address width
// PORTS
//  clk            in   1             clock
//  rstn           in   1             async active-low reset
//  q_start        in   1             arm pulse (ignored unless IDLE)
//  q_width        in   W_SIZE        pixels per line (>=1)
//  q_frame_size   in   W_FRAME_SIZE  pixels per frame (>=1)
//  q_base_addr    in   W_ADDR        first SRAM word address
//  i_vsync_run    in   1             frame-start blanking from the generator
//  i_hsync_run    in   1             line-start blanking from the generator
//  i_data_valid   in   1             one result pixel on i_data this cycle
//  i_data         in   8             result pixel
//  o_wr_en        out  1             SRAM write strobe, 1 cycle
//  o_wr_addr      out  W_ADDR        SRAM word address
//  o_wr_data      out  32            packed word; byte k = k-th pixel of the group
//  o_wr_be        out  4             byte enables
//  o_row, o_col   out  W_SIZE        position of the next expected pixel
//  o_pix_count    out  W_FRAME_SIZE  pixels accepted this frame
//  o_busy         out  1             state != IDLE
//  o_frame_done   out  1             1-cycle pulse at end of frame
//  o_line_err     out  1             sticky: short line detected
//  o_frame_err    out  1             sticky: vsync before frame complete
// BEHAVIOUR
//  Reset: all outputs 0. State = IDLE. Packer empty. Sticky errors cleared.
//  Sticky errors also clear on an accepted q_start.
//  vs_rise = i_vsync_run & ~vsync_d, where vsync_d is i_vsync_run registered.
//  States:
//   IDLE  -> ARM on q_start. Loads wr_addr=q_base_addr and clears counters and packer.
//   ARM   -> RECV on vs_rise.
//   RECV:
//    - Accept i_data when i_data_valid. Store the byte in lane pix_count[1:0].
//    - Per accepted pixel: col++. At col==q_width-1, col<=0 and row++. pix_count++.
//    - Lane 3 filled, or last pixel (pix_count==q_frame_size-1):
//      next cycle o_wr_en=1 at wr_addr, then wr_addr++.
//      o_wr_be = 4'b1111, or the low (n) lanes for a partial last word (n=1..3).
//    - After the last pixel -> DONE.
//    - i_hsync_run high with col!=0: set o_line_err, col<=0, row++.
//      An accepted pixel in the same cycle is counted before this realignment.
//    - vs_rise with pix_count!=0: set o_frame_err -> FLUSH.
//      A pixel valid in the same cycle is accepted first.
//   FLUSH -> DONE. If the packer is non-empty, write the partial word (lane-based be) this cycle.
//   DONE: o_frame_done=1 for exactly 1 cycle -> IDLE. Counters hold their final values until next start.
//  Latency: accepted pixel to its o_wr_en is 1 cycle. o_wr_data and o_wr_be are valid only with o_wr_en.
//  i_data_valid outside RECV is ignored. No back-pressure: SRAM accepts a write every cycle.
//  wr_addr wraps modulo 2^W_ADDR.
//  Reset mid-frame: immediate return to IDLE. No write is issued and the partial word is discarded.
// TESTING
//  T1 width=4, size=8, base=0x10; pixels 1..8 -> writes (0x10,0x04030201,F), (0x11,0x08070605,F); done pulse.
//  T2 width=3, size=9; pixels 1..9 -> 2 full words, then (base+2,0x00000009,be=0001); row=3.
//  T3 width=4; hsync after 2 pixels -> o_line_err=1, col=0, row=1; frame still completes on count.
//  T4 size=8; vs_rise after 5 pixels -> o_frame_err=1; write be=0001 for pixel 5; done pulse; IDLE.
//  T5 rstn low after 3 pixels -> no o_wr_en, all outputs 0; re-arm and full frame passes as T1.
//  T6 q_start during RECV -> ignored: addresses and counters unaffected; frame ends normally.

Source files
------------

// File: rtl/cnn_out_collector.sv
// ---------------------------------------------------------------------------
// cnn_out_collector
//   Receive side of the accelerator timing generator. Follows the
//   vsync/hsync/data-valid stream and takes one 8-bit result per accepted
//   pixel. It tracks the row, column and pixel count, packs four pixels per
//   32-bit little-endian word and writes each word to the output SRAM. It
//   flags short lines and truncated frames, and pulses frame completion.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   q_start                arm request (only honoured in IDLE)
//   q_width, q_frame_size  line length and frame length in pixels
//   q_base_addr            first SRAM word address of the frame
//   i_vsync_run            frame-start blanking (rising edge starts/aborts)
//   i_hsync_run            line-start blanking (realigns a short line)
//   i_data_valid, i_data   one result pixel per cycle
//   o_wr_en/addr/data/be   SRAM write port; data/be valid only with o_wr_en
//   o_row, o_col           position of the next expected pixel
//   o_pix_count            pixels accepted in the current frame
//   o_busy, o_frame_done   activity flag, 1-cycle end-of-frame pulse
//   o_line_err, o_frame_err  sticky error flags, cleared by q_start
// ---------------------------------------------------------------------------
module cnn_out_collector #(
  parameter int W_SIZE       = 12,
  parameter int W_FRAME_SIZE = 25,
  parameter int W_ADDR       = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    q_start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_FRAME_SIZE-1:0] q_frame_size,
  input  logic [W_ADDR-1:0]       q_base_addr,
  input  logic                    i_vsync_run,
  input  logic                    i_hsync_run,
  input  logic                    i_data_valid,
  input  logic [7:0]              i_data,
  output logic                    o_wr_en,
  output logic [W_ADDR-1:0]       o_wr_addr,
  output logic [31:0]             o_wr_data,
  output logic [3:0]              o_wr_be,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_FRAME_SIZE-1:0] o_pix_count,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_line_err,
  output logic                    o_frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RECV, S_FLUSH, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    vsync_d_reg;
  logic [W_ADDR-1:0]       wr_addr_reg, wr_addr_next;
  logic [31:0]             pack_reg, pack_next;
  logic [W_SIZE-1:0]       row_reg, row_next, col_reg, col_next;
  logic [W_FRAME_SIZE-1:0] pix_reg, pix_next;
  logic                    line_err_reg, line_err_next;
  logic                    frame_err_reg, frame_err_next;
  logic                    wr_en_reg, wr_en_next;
  logic [W_ADDR-1:0]       wr_addr_o_reg, wr_addr_o_next;
  logic [31:0]             wr_data_reg, wr_data_next;
  logic [3:0]              wr_be_reg, wr_be_next;

  logic       vs_rise, accept, last_pix, vs_err;
  logic [1:0] lane;
  logic [2:0] fill;      // bytes held in the packer after this cycle's pixel
  logic [31:0] word;     // packer contents including this cycle's pixel

  assign vs_rise  = i_vsync_run & ~vsync_d_reg;
  assign lane     = pix_reg[1:0];
  assign accept   = (state_reg == S_RECV) & i_data_valid;
  assign last_pix = (pix_reg == q_frame_size - 1'b1);
  assign vs_err   = (state_reg == S_RECV) & vs_rise & (pix_reg != '0);

  always_comb begin
    state_next     = state_reg;
    wr_addr_next   = wr_addr_reg;
    pack_next      = pack_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    pix_next       = pix_reg;
    line_err_next  = line_err_reg;
    frame_err_next = frame_err_reg;
    wr_en_next     = 1'b0;
    wr_addr_o_next = wr_addr_o_reg;
    wr_data_next   = wr_data_reg;
    wr_be_next     = wr_be_reg;
    word           = pack_reg;
    fill           = {1'b0, lane};

    case (state_reg)
      S_IDLE: begin
        if (q_start) begin
          state_next     = S_ARM;
          wr_addr_next   = q_base_addr;
          pack_next      = '0;
          row_next       = '0;
          col_next       = '0;
          pix_next       = '0;
          line_err_next  = 1'b0;
          frame_err_next = 1'b0;
        end
      end
      S_ARM: begin
        if (vs_rise) state_next = S_RECV;
      end
      S_RECV: begin
        if (accept) begin
          word     = pack_reg | ({24'd0, i_data} << {lane, 3'b000});
          fill     = {1'b0, lane} + 3'd1;
          pix_next = pix_reg + 1'b1;
          if (col_reg == q_width - 1'b1) begin
            col_next = '0;
            row_next = row_reg + 1'b1;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
        // Realignment is judged on the column after this cycle's pixel.
        if (i_hsync_run && (col_next != '0)) begin
          line_err_next = 1'b1;
          col_next      = '0;
          row_next      = row_next + 1'b1;
        end
        // A truncating vsync schedules the partial-word write here so that
        // it is presented on the port during the FLUSH cycle.
        if ((accept && ((lane == 2'd3) || last_pix)) || (vs_err && (fill != 3'd0))) begin
          wr_en_next     = 1'b1;
          wr_addr_o_next = wr_addr_reg;
          wr_data_next   = word;
          wr_be_next     = (fill == 3'd4) ? 4'b1111 : 4'((5'd1 << fill) - 5'd1);
          wr_addr_next   = wr_addr_reg + 1'b1;
          pack_next      = '0;
        end else begin
          pack_next = word;
        end
        if (vs_err) begin
          frame_err_next = 1'b1;
          state_next     = S_FLUSH;
        end else if (accept && last_pix) begin
          state_next = S_DONE;
        end
      end
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      vsync_d_reg   <= 1'b0;
      wr_addr_reg   <= '0;
      pack_reg      <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      pix_reg       <= '0;
      line_err_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_o_reg <= '0;
      wr_data_reg   <= '0;
      wr_be_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      vsync_d_reg   <= i_vsync_run;
      wr_addr_reg   <= wr_addr_next;
      pack_reg      <= pack_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      pix_reg       <= pix_next;
      line_err_reg  <= line_err_next;
      frame_err_reg <= frame_err_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_o_reg <= wr_addr_o_next;
      wr_data_reg   <= wr_data_next;
      wr_be_reg     <= wr_be_next;
    end
  end

  assign o_wr_en      = wr_en_reg;
  assign o_wr_addr    = wr_addr_o_reg;
  assign o_wr_data    = wr_data_reg;
  assign o_wr_be      = wr_be_reg;
  assign o_row        = row_reg;
  assign o_col        = col_reg;
  assign o_pix_count  = pix_reg;
  assign o_busy       = (state_reg != S_IDLE);
  assign o_frame_done = (state_reg == S_DONE);
  assign o_line_err   = line_err_reg;
  assign o_frame_err  = frame_err_reg;

endmodule

// File: tb/tb_cnn_out_collector.sv
// ---------------------------------------------------------------------------
// tb_cnn_out_collector
//   Scoreboard bench: a packing model queues each expected SRAM write as
//   pixels are driven; a negedge monitor pops and compares every write.
//   Status outputs are compared against hand-derived values per scenario.
// ---------------------------------------------------------------------------
module tb_cnn_out_collector;

  logic        clk = 1'b0;
  logic        rstn;
  logic        q_start;
  logic [11:0] q_width;
  logic [24:0] q_frame_size;
  logic [15:0] q_base_addr;
  logic        i_vsync_run, i_hsync_run, i_data_valid;
  logic [7:0]  i_data;
  logic        o_wr_en;
  logic [15:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic [3:0]  o_wr_be;
  logic [11:0] o_row, o_col;
  logic [24:0] o_pix_count;
  logic        o_busy, o_frame_done, o_line_err, o_frame_err;

  cnn_out_collector dut (
    .clk(clk), .rstn(rstn), .q_start(q_start), .q_width(q_width),
    .q_frame_size(q_frame_size), .q_base_addr(q_base_addr),
    .i_vsync_run(i_vsync_run), .i_hsync_run(i_hsync_run),
    .i_data_valid(i_data_valid), .i_data(i_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_wr_be(o_wr_be), .o_row(o_row), .o_col(o_col),
    .o_pix_count(o_pix_count), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_line_err(o_line_err), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  done_cnt = 0;
  int  exp_done = 0;

  // packing model
  logic [15:0] m_addr;
  logic [31:0] m_pack;
  int          m_n, m_cnt, m_size;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  always @(negedge clk) begin
    if (o_frame_done) done_cnt++;
    if (o_wr_en) begin
      if (sb.size() == 0) begin
        check("wr_unexpected_addr", {48'd0, o_wr_addr}, 64'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {48'd0, o_wr_addr}, {48'd0, e.addr});
        check("wr_data", {32'd0, o_wr_data}, {32'd0, e.data});
        check("wr_be",   {60'd0, o_wr_be},   {60'd0, e.be});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] be_of(input int n);
    return (n >= 4) ? 4'b1111 : 4'((1 << n) - 1);
  endfunction

  task automatic push_word;
    wr_t e;
    e.addr = m_addr; e.data = m_pack; e.be = be_of(m_n);
    sb.push_back(e);
    m_addr = m_addr + 16'd1;
    m_pack = '0;
    m_n    = 0;
  endtask

  task automatic arm(input int width, input int size, input logic [15:0] base);
    q_width = 12'(width); q_frame_size = 25'(size); q_base_addr = base;
    q_start = 1'b1;
    tick;
    q_start = 1'b0;
    m_addr = base; m_pack = '0; m_n = 0; m_cnt = 0; m_size = size;
  endtask

  task automatic vs_pulse;
    i_vsync_run = 1'b1;
    tick; tick;
    i_vsync_run = 1'b0;
    tick;
  endtask

  task automatic vs_abort;
    if (m_n != 0) push_word();
    vs_pulse();
  endtask

  task automatic pixel(input logic [7:0] d);
    m_pack = m_pack | ({24'd0, d} << (8 * m_n));
    m_n++;
    m_cnt++;
    if (m_n == 4 || m_cnt == m_size) push_word();
    i_data_valid = 1'b1; i_data = d;
    tick;
    i_data_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_done++;
    for (int i = 0; i < 20 && done_cnt < exp_done; i++) tick;
    tick; tick;
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_sb_drain"}, 64'(sb.size()), 64'd0);
    check({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
  endtask

  task automatic t1_frame(input string tag);
    arm(4, 8, 16'h0010);
    vs_pulse();
    for (int i = 1; i <= 8; i++) pixel(8'(i));
    wait_done(tag);
    check({tag, "_pix"}, 64'(o_pix_count), 64'd8);
    check({tag, "_row"}, 64'(o_row), 64'd2);
  endtask

  initial begin
    rstn = 1'b0; q_start = 1'b0; q_width = '0; q_frame_size = '0; q_base_addr = '0;
    i_vsync_run = 1'b0; i_hsync_run = 1'b0; i_data_valid = 1'b0; i_data = '0;
    tick; tick;
    check("rst_outputs", {o_wr_en, o_wr_addr, o_wr_data, o_wr_be, o_busy, o_frame_done,
                          o_line_err, o_frame_err}, 64'd0);
    check("rst_counts", {o_row, o_col, o_pix_count}, 64'd0);
    rstn = 1'b1;
    tick;

    // T1: two full words
    t1_frame("t1");

    // T2: partial last word
    arm(3, 9, 16'h0200);
    vs_pulse();
    for (int i = 1; i <= 9; i++) pixel(8'(i));
    wait_done("t2");
    check("t2_row", 64'(o_row), 64'd3);
    check("t2_col", 64'(o_col), 64'd0);

    // T3: short line realigned by hsync
    arm(4, 8, 16'h0300);
    vs_pulse();
    pixel(8'hA1); pixel(8'hA2);
    i_hsync_run = 1'b1;
    tick;
    i_hsync_run = 1'b0;
    check("t3_line_err", {63'd0, o_line_err}, 64'd1);
    check("t3_col", 64'(o_col), 64'd0);
    check("t3_row", 64'(o_row), 64'd1);
    for (int i = 3; i <= 8; i++) pixel(8'(8'hA0 + i));
    wait_done("t3");
    check("t3_end_pos", {40'd0, o_row, o_col}, {40'd0, 12'd2, 12'd2});
    check("t3_frame_err", {63'd0, o_frame_err}, 64'd0);

    // T4: truncated frame flushes a one-byte word
    arm(4, 8, 16'h0400);
    check("t4_err_cleared", {62'd0, o_line_err, o_frame_err}, 64'd0);
    vs_pulse();
    for (int i = 1; i <= 5; i++) pixel(8'(8'h50 + i));
    vs_abort();
    check("t4_frame_err", {63'd0, o_frame_err}, 64'd1);
    wait_done("t4");
    check("t4_pix", 64'(o_pix_count), 64'd5);

    // T5: reset mid-frame discards the partial word
    arm(4, 8, 16'h0010);
    vs_pulse();
    pixel(8'h71); pixel(8'h72); pixel(8'h73);
    rstn = 1'b0;
    #1;
    check("t5_rst_outputs", {o_wr_en, o_wr_addr, o_wr_data, o_wr_be, o_busy, o_frame_done,
                             o_line_err, o_frame_err}, 64'd0);
    check("t5_rst_counts", {o_row, o_col, o_pix_count}, 64'd0);
    tick; tick;
    rstn = 1'b1;
    tick;
    t1_frame("t5");

    // T6: start while receiving is ignored
    arm(4, 8, 16'h0010);
    vs_pulse();
    pixel(8'h01); pixel(8'h02); pixel(8'h03);
    q_base_addr = 16'h0555; q_start = 1'b1;
    tick;
    q_start = 1'b0;
    check("t6_busy", {63'd0, o_busy}, 64'd1);
    check("t6_pix", 64'(o_pix_count), 64'd3);
    for (int i = 4; i <= 8; i++) pixel(8'(i));
    wait_done("t6");
    check("t6_pix_end", 64'(o_pix_count), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
